// File: rtl/sephirot_mpram.sv
// sephirot_mpram -- multi-port lane-local data memory for the Sephirot VLIW core.
//
// One read port and one write port per lane, byte-enable writes, per-byte
// write-conflict resolution (the highest-index lane wins each byte) with a
// one-cycle conflict pulse, and a clear sequencer that zeroes the array one
// word per cycle after reset or on request.
//
// Optional feature macro: RAM_WR_FWD_EN
//   defined   -> a read and a write to the same address in the same cycle
//                return the freshly merged word (bypass mux per read lane)
//   undefined -> the same case returns the stored pre-write word
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   clear        single-cycle request to zero the whole array
//   busy         high while the clear sweep runs (all ports ignored)
//   rd_en        per-lane read strobe
//   rd_addr      lane i at [i*ADDR_W +: ADDR_W]
//   rd_data      lane i at [i*DATA_W +: DATA_W], 1-cycle latency, holds when idle
//   rd_valid     per-lane read data valid
//   wr_en        per-lane write strobe
//   wr_addr      lane i at [i*ADDR_W +: ADDR_W]
//   wr_be        lane i at [i*DATA_W/8 +: DATA_W/8]
//   wr_data      lane i at [i*DATA_W +: DATA_W]
//   wr_conflict  lane i lost at least one enabled byte to a higher lane
module sephirot_mpram #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear,
  output logic                            busy,
  input  logic [NUM_PORTS-1:0]            rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]     rd_addr,
  output logic [NUM_PORTS*DATA_W-1:0]     rd_data,
  output logic [NUM_PORTS-1:0]            rd_valid,
  input  logic [NUM_PORTS-1:0]            wr_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]     wr_addr,
  input  logic [NUM_PORTS*DATA_W/8-1:0]   wr_be,
  input  logic [NUM_PORTS*DATA_W-1:0]     wr_data,
  output logic [NUM_PORTS-1:0]            wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BYTES = DATA_W / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
  logic                accept;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   rd_addr_w [NUM_PORTS];
  logic [ADDR_W-1:0]   wr_addr_w [NUM_PORTS];
  logic [BYTES-1:0]    wr_be_w   [NUM_PORTS];
  logic [DATA_W-1:0]   wr_data_w [NUM_PORTS];
  logic [DATA_W-1:0]   rd_word_w [NUM_PORTS];
  logic [NUM_PORTS-1:0] conflict_w;

  logic [DATA_W-1:0]    rd_data_reg [NUM_PORTS];
  logic [NUM_PORTS-1:0] rd_valid_reg;
  logic [NUM_PORTS-1:0] conflict_reg;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (clear) begin
          clr_cnt_next = '0;                      // restart the sweep
        end else if (clr_cnt_reg == {ADDR_W{1'b1}}) begin
          state_next   = ST_READY;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      ST_READY: begin
        if (clear) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      default: begin
        state_next   = ST_CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  assign accept = (state_reg == ST_READY);
  assign busy   = ~accept;

  // ---------------- per-lane unpacking, bypass and conflict detect ----------------
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_lane
      logic [DATA_W-1:0] rd_word;
      logic              conf;

      assign rd_addr_w[gi] = rd_addr[gi*ADDR_W +: ADDR_W];
      assign wr_addr_w[gi] = wr_addr[gi*ADDR_W +: ADDR_W];
      assign wr_be_w[gi]   = wr_be[gi*BYTES +: BYTES];
      assign wr_data_w[gi] = wr_data[gi*DATA_W +: DATA_W];

`ifdef RAM_WR_FWD_EN
      // Lanes are applied in ascending order so the highest lane ends up
      // owning each byte, matching the write-side priority.
      always_comb begin
        rd_word = mem[rd_addr_w[gi]];
        for (int l = 0; l < NUM_PORTS; l++) begin
          if (wr_en[l] && (wr_addr_w[l] == rd_addr_w[gi])) begin
            for (int b = 0; b < BYTES; b++) begin
              if (wr_be_w[l][b]) rd_word[b*8 +: 8] = wr_data_w[l][b*8 +: 8];
            end
          end
        end
      end
`else
      assign rd_word = mem[rd_addr_w[gi]];
`endif
      assign rd_word_w[gi] = rd_word;

      // Lane gi loses if any higher lane writes an overlapping byte of the same word.
      always_comb begin
        conf = 1'b0;
        for (int j = 0; j < NUM_PORTS; j++) begin
          if ((j > gi) && wr_en[gi] && wr_en[j] &&
              (wr_addr_w[j] == wr_addr_w[gi]) && |(wr_be_w[gi] & wr_be_w[j]))
            conf = 1'b1;
        end
      end
      assign conflict_w[gi] = conf;

      assign rd_data[gi*DATA_W +: DATA_W] = rd_data_reg[gi];
    end
  endgenerate

  // ---------------- storage array ----------------
  // Later lanes in the loop override earlier ones, so the highest enabled
  // lane wins each byte independently.
  always_ff @(posedge clk) begin
    if (!accept) begin
      mem[clr_cnt_reg] <= '0;
    end else begin
      for (int l = 0; l < NUM_PORTS; l++) begin
        if (wr_en[l]) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wr_be_w[l][b]) mem[wr_addr_w[l]][b*8 +: 8] <= wr_data_w[l][b*8 +: 8];
          end
        end
      end
    end
  end

  // ---------------- read and conflict output registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) rd_data_reg[i] <= '0;
      rd_valid_reg <= '0;
      conflict_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_valid_reg[i] <= accept & rd_en[i];
        if (accept && rd_en[i]) rd_data_reg[i] <= rd_word_w[i];
      end
      conflict_reg <= accept ? conflict_w : '0;
    end
  end

  assign rd_valid    = rd_valid_reg;
  assign wr_conflict = conflict_reg;

endmodule
